// File: rtl/tl45_wb_arbiter.sv
// Two-master (M0 = memory stage, M1 = fetch) to one-slave Wishbone arbiter for the tl45 core.
// Define TL45_WB_ARB_TIMEOUT_EN to add a watchdog that aborts an owner stuck without ack/err.
module tl45_wb_arbiter #(
    parameter bit          RR_EN_DEFAULT  = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [3:0]  i_m0_sel,
    output logic        o_m0_ack,
    output logic        o_m0_stall,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,

    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [3:0]  i_m1_sel,
    output logic        o_m1_ack,
    output logic        o_m1_stall,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,

    output logic [1:0]  o_owner
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    state_t state;
    logic   last_owner;   // 0 = M0, 1 = M1
    logic   own0;
    logic   own1;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

`ifdef TL45_WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             owner_cyc;

    assign owner_cyc = (own0 & i_m0_cyc) | (own1 & i_m1_cyc);

    // This cycle is the TIMEOUT_CYCLES-th in a row with the owner waiting on the slave.
    assign timeout = owner_cyc & ~i_wb_ack & ~i_wb_err
                   & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle/abort and every handoff pass through a cycle without owner_cyc, which clears the count.
    always_ff @(posedge i_clk) begin
        if (i_reset || !owner_cyc || i_wb_ack || i_wb_err)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Ownership state; grants are never preempted, only released by the owner dropping cyc.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_cyc && i_m1_cyc)
                        state <= (RR_EN_DEFAULT && !last_owner) ? OWN1 : OWN0;
                    else if (i_m0_cyc)
                        state <= OWN0;
                    else if (i_m1_cyc)
                        state <= OWN1;
                end
                OWN0: begin
                    if (i_m0_cyc) begin
                        last_owner <= 1'b0;
                        if (timeout)
                            state <= ABORT;
                    end else begin
                        state <= i_m1_cyc ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (i_m1_cyc) begin
                        last_owner <= 1'b1;
                        if (timeout)
                            state <= ABORT;
                    end else begin
                        state <= i_m0_cyc ? OWN0 : IDLE;
                    end
                end
                ABORT: begin
                    if (!(last_owner ? i_m1_cyc : i_m0_cyc))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave-side mux and response steering, driven from the registered owner.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        if (own0) begin
            o_wb_cyc  = i_m0_cyc & ~timeout;
            o_wb_stb  = i_m0_cyc & i_m0_stb & ~timeout;
            o_wb_we   = i_m0_we;
            o_wb_addr = i_m0_addr;
            o_wb_data = i_m0_data;
            o_wb_sel  = i_m0_sel;
        end else if (own1) begin
            o_wb_cyc  = i_m1_cyc & ~timeout;
            o_wb_stb  = i_m1_cyc & i_m1_stb & ~timeout;
            o_wb_we   = i_m1_we;
            o_wb_addr = i_m1_addr;
            o_wb_data = i_m1_data;
            o_wb_sel  = i_m1_sel;
        end

        o_m0_stall = own0 ? i_wb_stall : 1'b1;
        o_m0_ack   = own0 & (i_wb_ack | timeout);
        o_m0_err   = own0 & (i_wb_err | timeout);
        o_m0_data  = own0 ? i_wb_data : 32'h0;

        o_m1_stall = own1 ? i_wb_stall : 1'b1;
        o_m1_ack   = own1 & (i_wb_ack | timeout);
        o_m1_err   = own1 & (i_wb_err | timeout);
        o_m1_data  = own1 ? i_wb_data : 32'h0;

        o_owner = {own1, own0};
    end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Directed bench for tl45_wb_arbiter: one fixed-priority and one round-robin instance on shared stimulus.
module tb_tl45_wb_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic        m0_cyc, m0_stb, m0_we;
    logic [29:0] m0_addr;
    logic [31:0] m0_data;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_we;
    logic [29:0] m1_addr;
    logic [31:0] m1_data;
    logic [3:0]  m1_sel;
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_rdata;

    logic        f_m0_ack, f_m0_stall, f_m0_err, f_m1_ack, f_m1_stall, f_m1_err;
    logic [31:0] f_m0_dout, f_m1_dout, f_wb_wdata;
    logic        f_wb_cyc, f_wb_stb, f_wb_we;
    logic [29:0] f_wb_addr;
    logic [3:0]  f_wb_sel;
    logic [1:0]  f_owner;

    logic        r_m0_ack, r_m0_stall, r_m0_err, r_m1_ack, r_m1_stall, r_m1_err;
    logic [31:0] r_m0_dout, r_m1_dout, r_wb_wdata;
    logic        r_wb_cyc, r_wb_stb, r_wb_we;
    logic [29:0] r_wb_addr;
    logic [3:0]  r_wb_sel;
    logic [1:0]  r_owner;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tl45_wb_arbiter #(.RR_EN_DEFAULT(1'b0), .TIMEOUT_CYCLES(8)) u_fix (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_data), .i_m0_sel(m0_sel),
        .o_m0_ack(f_m0_ack), .o_m0_stall(f_m0_stall), .o_m0_err(f_m0_err), .o_m0_data(f_m0_dout),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_data), .i_m1_sel(m1_sel),
        .o_m1_ack(f_m1_ack), .o_m1_stall(f_m1_stall), .o_m1_err(f_m1_err), .o_m1_data(f_m1_dout),
        .o_wb_cyc(f_wb_cyc), .o_wb_stb(f_wb_stb), .o_wb_we(f_wb_we), .o_wb_addr(f_wb_addr),
        .o_wb_data(f_wb_wdata), .o_wb_sel(f_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_owner(f_owner)
    );

    tl45_wb_arbiter #(.RR_EN_DEFAULT(1'b1), .TIMEOUT_CYCLES(8)) u_rr (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_data), .i_m0_sel(m0_sel),
        .o_m0_ack(r_m0_ack), .o_m0_stall(r_m0_stall), .o_m0_err(r_m0_err), .o_m0_data(r_m0_dout),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_data), .i_m1_sel(m1_sel),
        .o_m1_ack(r_m1_ack), .o_m1_stall(r_m1_stall), .o_m1_err(r_m1_err), .o_m1_data(r_m1_dout),
        .o_wb_cyc(r_wb_cyc), .o_wb_stb(r_wb_stb), .o_wb_we(r_wb_we), .o_wb_addr(r_wb_addr),
        .o_wb_data(r_wb_wdata), .o_wb_sel(r_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_owner(r_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_data = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_data = '0; m1_sel = '0;
        wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;
        repeat (3) tick();
        #1;
        check("rst_f_wb_cyc",   32'(f_wb_cyc), 0);
        check("rst_f_wb_stb",   32'(f_wb_stb), 0);
        check("rst_f_wb_we",    32'(f_wb_we), 0);
        check("rst_f_wb_addr",  32'(f_wb_addr), 0);
        check("rst_f_wb_data",  f_wb_wdata, 0);
        check("rst_f_wb_sel",   32'(f_wb_sel), 0);
        check("rst_f_m0",       32'({f_m0_ack, f_m0_stall, f_m0_err}), 32'b010);
        check("rst_f_m1",       32'({f_m1_ack, f_m1_stall, f_m1_err}), 32'b010);
        check("rst_f_dout",     f_m0_dout | f_m1_dout, 0);
        check("rst_f_owner",    32'(f_owner), 0);
        check("rst_r_wb",       32'({r_wb_cyc, r_wb_stb, r_wb_we, r_wb_sel}), 0);
        check("rst_r_wb_addr",  32'(r_wb_addr) | r_wb_wdata, 0);
        check("rst_r_m0",       32'({r_m0_ack, r_m0_stall, r_m0_err}), 32'b010);
        check("rst_r_m1",       32'({r_m1_ack, r_m1_stall, r_m1_err}), 32'b010);
        check("rst_r_dout",     r_m0_dout | r_m1_dout, 0);
        check("rst_r_owner",    32'(r_owner), 0);
        rst = 1'b0;

        // Single M0 read: grant one cycle after request, ack routed to M0 only
        tick();
        m0_cyc = 1; m0_stb = 1; m0_addr = 30'h0000_0100; m0_sel = 4'hF; m0_we = 0;
        #1;
        check("t1_stb_latency", 32'(f_wb_stb), 0);
        check("t1_owner_pre",   32'(f_owner), 0);
        tick();
        #1;
        check("t1_owner",   32'(f_owner), 32'h1);
        check("t1_wb_stb",  32'(f_wb_stb), 1);
        check("t1_wb_addr", 32'(f_wb_addr), 32'h100);
        check("t1_wb_sel",  32'(f_wb_sel), 32'hF);
        check("t1_m1_stall", 32'(f_m1_stall), 1);
        check("t1_rr_owner", 32'(r_owner), 32'h1);
        tick();
        m0_stb = 0; wb_ack = 1; wb_rdata = 32'hDEADBEEF;
        #1;
        check("t1_m0_ack",  32'(f_m0_ack), 1);
        check("t1_m0_data", f_m0_dout, 32'hDEADBEEF);
        check("t1_m1_ack",  32'(f_m1_ack), 0);
        check("t1_m1_data", f_m1_dout, 0);
        check("t1_m1_stall_ack", 32'(f_m1_stall), 1);
        tick();
        wb_ack = 0; m0_cyc = 0;
        #1;
        check("t1_drop_cyc",   32'(f_wb_cyc), 0);
        check("t1_drop_owner", 32'(f_owner), 32'h1);
        tick();
        #1;
        check("t1_idle_owner", 32'(f_owner), 0);

        // Stray ack/err while idle goes nowhere
        wb_ack = 1; wb_err = 1;
        #1;
        check("stray_f_acks", 32'({f_m0_ack, f_m1_ack, f_m0_err, f_m1_err}), 0);
        check("stray_r_acks", 32'({r_m0_ack, r_m1_ack, r_m0_err, r_m1_err}), 0);
        tick();
        wb_ack = 0; wb_err = 0;
        #1;
        check("stray_f_owner", 32'(f_owner), 0);
        check("stray_r_owner", 32'(r_owner), 0);

        // M1 request that drops on its first granted cycle
        m1_cyc = 1; m1_stb = 1; m1_addr = 30'h0000_0300; m1_sel = 4'h3; m1_we = 1; m1_data = 32'hA5A5_0001;
        #1;
        tick();
        m1_cyc = 0; m1_stb = 0;
        #1;
        check("gd_owner",  32'(f_owner), 32'h2);
        check("gd_wb_cyc", 32'(f_wb_cyc), 0);
        tick();
        #1;
        check("gd_idle", 32'(f_owner), 0);

        // Simultaneous request: fixed picks M0, RR (last owner M0) picks M1
        m0_cyc = 1; m0_stb = 1; m0_addr = 30'h0000_0200;
        m1_cyc = 1; m1_stb = 1;
        #1;
        tick();
        #1;
        check("both_f_owner", 32'(f_owner), 32'h1);
        check("both_r_owner", 32'(r_owner), 32'h2);
        check("both_f_addr",  32'(f_wb_addr), 32'h200);
        check("both_r_addr",  32'(r_wb_addr), 32'h300);
        check("both_r_wdata", r_wb_wdata, 32'hA5A5_0001);
        check("both_r_we_sel", 32'({r_wb_we, r_wb_sel}), 32'h13);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            wb_stall = 1;
            #1;
            check("stall_r_m1", 32'(r_m1_stall), 1);
            check("stall_r_m0", 32'({r_m0_stall, r_m0_ack}), 32'b10);
            check("stall_r_stb", 32'(r_wb_stb), 1);
        end
        tick();
        wb_stall = 0;
        #1;
        check("unstall_r_m1", 32'(r_m1_stall), 0);
        check("unstall_r_m0", 32'(r_m0_stall), 1);
        check("unstall_f_m0", 32'(f_m0_stall), 0);
        check("unstall_f_m1", 32'(f_m1_stall), 1);
        tick();
        m0_stb = 0; m1_stb = 0; wb_ack = 1; wb_rdata = 32'h1234_5678;
        #1;
        check("ack_f", 32'({f_m0_ack, f_m1_ack}), 32'b10);
        check("ack_r", 32'({r_m0_ack, r_m1_ack}), 32'b01);
        check("ack_r_m1_data", r_m1_dout, 32'h1234_5678);
        check("ack_r_m0_data", r_m0_dout, 0);
        tick();
        wb_ack = 0; m0_cyc = 0;
        #1;
        check("hand_f_cyc",   32'(f_wb_cyc), 0);
        check("hand_f_owner", 32'(f_owner), 32'h1);
        check("hand_r_cyc",   32'(r_wb_cyc), 1);
        tick();
        #1;
        check("hand_f_owner2", 32'(f_owner), 32'h2);
        check("hand_f_addr",   32'(f_wb_addr), 32'h300);
        check("hand_f_cyc2",   32'(f_wb_cyc), 1);
        tick();
        m1_cyc = 0;
        #1;
        check("rel_cycs", 32'({f_wb_cyc, r_wb_cyc}), 0);
        tick();
        #1;
        check("rel_owners", 32'({f_owner, r_owner}), 0);

        // Continuous contention for four transactions: owners alternate 01,10,01,10
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_owner;
            exp_owner = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            m0_cyc = 1; m1_cyc = 1; wb_ack = 1;
            #1;
            check("rr_r_owner", 32'(r_owner), 32'(exp_owner));
            check("rr_f_owner", 32'(f_owner), 32'(exp_owner));
            check("rr_r_ack", 32'({r_m1_ack, r_m0_ack}), 32'(exp_owner));
            tick();
            wb_ack = 0;
            if (exp_owner == 2'b01) m0_cyc = 0; else m1_cyc = 0;
            #1;
            check("rr_gap_cyc", 32'(r_wb_cyc), 0);
        end
        tick();
        m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0;
        tick();
        #1;
        check("rr_idle", 32'({f_owner, r_owner}), 0);

`ifdef TL45_WB_ARB_TIMEOUT_EN
        // Unacked M0 write aborts on its 8th owned cycle, then pending M1 gets the bus
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 30'h0000_0040; m0_data = 32'hCAFE_F00D;
        #1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) m1_cyc = 1;
            #1;
            if (k < 8) begin
                check("tmo_wait_ack", 32'({f_m0_ack, f_m0_err}), 0);
                check("tmo_wait_cyc", 32'(f_wb_cyc), 1);
            end else begin
                check("tmo_f_ackerr", 32'({f_m0_ack, f_m0_err}), 32'b11);
                check("tmo_f_cyc",    32'(f_wb_cyc), 0);
                check("tmo_r_ackerr", 32'({r_m0_ack, r_m0_err}), 32'b11);
            end
        end
        tick();
        #1;
        check("abort_owner", 32'(f_owner), 0);
        check("abort_cyc",   32'(f_wb_cyc), 0);
        check("abort_m0",    32'({f_m0_ack, f_m0_err, f_m0_stall}), 32'b001);
        check("abort_m1",    32'(f_m1_stall), 1);
        tick();
        m0_cyc = 0; m0_stb = 0;
        #1;
        check("abort_drop_cyc", 32'(f_wb_cyc), 0);
        tick();
        #1;
        check("abort_idle", 32'(f_owner), 0);
        tick();
        #1;
        check("abort_m1_grant_f", 32'(f_owner), 32'h2);
        check("abort_m1_grant_r", 32'(r_owner), 32'h2);
`else
        // Without the watchdog an unacked owner keeps the bus indefinitely
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 30'h0000_0040; m0_data = 32'hCAFE_F00D;
        #1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) m1_cyc = 1;
        end
        #1;
        check("hold_owner",  32'(f_owner), 32'h1);
        check("hold_cyc",    32'(f_wb_cyc), 1);
        check("hold_m0",     32'({f_m0_ack, f_m0_err}), 0);
        check("hold_m1",     32'(f_m1_stall), 1);
        check("hold_r_err",  32'({r_m0_err, r_m1_err, f_m1_err}), 0);
`endif
        tick();
        m0_cyc = 0; m1_cyc = 0; m0_stb = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
